// File: rtl/regfile_param_if.sv
// regfile_param_if: operand/write bus between datapath and regfile_param
//   master drives: alu, reg_src, imm, mem (write sources), ms (source select),
//                  we, wa (write), ra0, ra1 (read addresses), clr_req
//   slave drives:  rd0, rd1 (combinational read data), busy (clear in progress)
interface regfile_param_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
) ();
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic [DATA_W-1:0] alu, reg_src, imm, mem, rd0, rd1;
  logic [1:0]        ms;
  logic              we, clr_req, busy;
  logic [ADDR_W-1:0] wa, ra0, ra1;
  modport master (output alu, reg_src, imm, mem, ms, we, wa, ra0, ra1, clr_req,
                  input rd0, rd1, busy);
  modport slave  (input alu, reg_src, imm, mem, ms, we, wa, ra0, ra1, clr_req,
                  output rd0, rd1, busy);
endinterface

// File: rtl/regfile_param.sv
// regfile_param: NUM_REGS x DATA_W register bank, 4-way write source, 2 read ports, sequenced clear
//   clk   : all state updates on the falling edge
//   rst_n : asynchronous active-low reset
//   bus   : regfile_param_if.slave (write sources/select/enable/address, read ports, clr_req/busy)
//   REGFILE_BYPASS_EN : when defined, a pending write is forwarded to a matching read port
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
) (
  input logic             clk,
  input logic             rst_n,
  regfile_param_if.slave  bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wdata;
  logic              wr_ok;
  always_comb begin
    wdata = bus.ms == 2'd0 ? bus.alu : bus.ms == 2'd1 ? bus.reg_src : bus.ms == 2'd2 ? bus.imm : bus.mem;
    wr_ok = bus.we && state_q == IDLE && 32'(bus.wa) < NUM_REGS;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (bus.clr_req) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end
  // A write on the request edge lands first; the clear then sweeps over it.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == CLEAR) regs[cnt_q] <= '0;
      else if (wr_ok) regs[bus.wa] <= wdata;
    end
  end
  always_comb begin
    bus.rd0 = 32'(bus.ra0) < NUM_REGS ? regs[bus.ra0] : '0;
    bus.rd1 = 32'(bus.ra1) < NUM_REGS ? regs[bus.ra1] : '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && bus.ra0 == bus.wa) bus.rd0 = wdata;
    if (wr_ok && bus.ra1 == bus.wa) bus.rd1 = wdata;
`endif
  end
  assign bus.busy = state_q == CLEAR;
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: table-driven and sequenced checks of regfile_param (8-reg and 6-reg instances)
module tb_regfile_param;
  logic clk = 1'b1;
  logic rst_n = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  regfile_param_if #(.DATA_W(8), .NUM_REGS(8)) b ();
  regfile_param_if #(.DATA_W(8), .NUM_REGS(6)) b6 ();
  regfile_param #(.DATA_W(8), .NUM_REGS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  regfile_param #(.DATA_W(8), .NUM_REGS(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));
  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [1:0] ms;
    logic [7:0] alu, rg, imm, mem;
    logic [2:0] ra0, ra1;
    logic [7:0] e0, e1;
  } vec_t;
  vec_t v[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    b.we = 1'b1; b.ms = 2'd0; b.wa = a; b.alu = d;
    tick();
    b.we = 1'b0;
  endtask
  task automatic count_busy(output int n);
    n = 0;
    while (b.busy && n < 20) begin
      n++;
      tick();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    v[0] = '{1'b1, 3'd3, 2'd0, 8'h5A, 8'h11, 8'h22, 8'h33, 3'd3, 3'd4, 8'h5A, 8'h00};
    v[1] = '{1'b1, 3'd4, 2'd2, 8'h44, 8'h55, 8'hC3, 8'h66, 3'd3, 3'd4, 8'h5A, 8'hC3};
    v[2] = '{1'b1, 3'd7, 2'd3, 8'h77, 8'h88, 8'h99, 8'hFF, 3'd7, 3'd4, 8'hFF, 8'hC3};
    v[3] = '{1'b1, 3'd0, 2'd1, 8'h01, 8'h12, 8'h02, 8'h03, 3'd0, 3'd0, 8'h12, 8'h12};
    v[4] = '{1'b0, 3'd5, 2'd0, 8'h99, 8'h98, 8'h97, 8'h96, 3'd5, 3'd3, 8'h00, 8'h5A};
    v[5] = '{1'b1, 3'd3, 2'd1, 8'h04, 8'h66, 8'h05, 8'h06, 3'd3, 3'd7, 8'h66, 8'hFF};
    {b.alu, b.reg_src, b.imm, b.mem, b.ms, b.we, b.wa, b.ra0, b.ra1, b.clr_req} = '0;
    {b6.alu, b6.reg_src, b6.imm, b6.mem, b6.ms, b6.we, b6.wa, b6.ra0, b6.ra1, b6.clr_req} = '0;
    #2;
    chk("init_rd0", b.rd0, 8'h00);
    chk("init_rd1", b.rd1, 8'h00);
    chk("init_busy", b.busy, 1'b0);
    #6 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b.we = v[i].we; b.wa = v[i].wa; b.ms = v[i].ms;
      b.alu = v[i].alu; b.reg_src = v[i].rg; b.imm = v[i].imm; b.mem = v[i].mem;
      b.ra0 = v[i].ra0; b.ra1 = v[i].ra1;
      tick();
      b.we = 1'b0;
      #1;
      chk($sformatf("vec%0d_rd0", i), b.rd0, v[i].e0);
      chk($sformatf("vec%0d_rd1", i), b.rd1, v[i].e1);
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd0", b.rd0, 8'h00);
    chk("async_rst_rd1", b.rd1, 8'h00);
    chk("async_rst_busy", b.busy, 1'b0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h11 * i + 1));
    b.clr_req = 1'b1;
    tick();
    b.clr_req = 1'b0;
    chk("clr_busy_start", b.busy, 1'b1);
    n = 0;
    while (b.busy && n < 20) begin
      n++;
      tick();
      if (n == 3) begin
        b.ra0 = 3'd2; b.ra1 = 3'd3;
        #1;
        chk("clr3_reg2", b.rd0, 8'h00);
        chk("clr3_reg3", b.rd1, 8'h34);
      end
    end
    chk("clr_busy_cycles", n, 8);
    for (int i = 0; i < 8; i++) begin
      b.ra0 = 3'(i);
      #1;
      chk($sformatf("clr_done_reg%0d", i), b.rd0, 8'h00);
    end
    tick();
    b.we = 1'b1; b.ms = 2'd0; b.wa = 3'd1; b.alu = 8'hAA; b.clr_req = 1'b1; b.ra0 = 3'd1; b.ra1 = 3'd5;
    tick();
    b.clr_req = 1'b0; b.wa = 3'd5;
    chk("simul_reg1_written", b.rd0, 8'hAA);
    chk("simul_busy", b.busy, 1'b1);
    tick();
    chk("simul_reg1_edge1", b.rd0, 8'hAA);
    tick();
    chk("simul_reg1_cleared", b.rd0, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    b.we = 1'b0;
    tick();
    chk("busy_wr_done", b.busy, 1'b0);
    chk("busy_wr_reg5", b.rd1, 8'h00);
    wr(3'd7, 8'h77);
    b.clr_req = 1'b1;
    tick();
    b.clr_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    b.ra0 = 3'd7; b.ra1 = 3'd7;
    #1;
    chk("midclr_reg7_kept", b.rd0, 8'h77);
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_busy", b.busy, 1'b0);
    chk("midclr_rst_reg7", b.rd1, 8'h00);
    #1 rst_n = 1'b1;
    b.clr_req = 1'b1;
    tick();
    b.clr_req = 1'b0;
    count_busy(n);
    chk("reclr_busy_cycles", n, 8);
    b6.we = 1'b1; b6.ms = 2'd2; b6.wa = 3'd5; b6.imm = 8'h55;
    tick();
    b6.wa = 3'd6; b6.imm = 8'hEE;
    tick();
    b6.we = 1'b0; b6.ra0 = 3'd6; b6.ra1 = 3'd5;
    #1;
    chk("n6_ra6", b6.rd0, 8'h00);
    chk("n6_reg5", b6.rd1, 8'h55);
    b6.ra0 = 3'd7;
    #1;
    chk("n6_ra7", b6.rd0, 8'h00);
    b6.clr_req = 1'b1;
    tick();
    b6.clr_req = 1'b0;
    n = 0;
    while (b6.busy && n < 20) begin
      n++;
      tick();
    end
    chk("n6_busy_cycles", n, 6);
    chk("n6_reg5_cleared", b6.rd1, 8'h00);
    wr(3'd2, 8'h10);
    b.ra1 = 3'd2; b.ms = 2'd0; b.alu = 8'h3C; b.wa = 3'd2; b.we = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_pre_edge", b.rd1, 8'h3C);
`else
    chk("nobypass_pre_edge", b.rd1, 8'h10);
`endif
    tick();
    b.we = 1'b0;
    #1;
    chk("bypass_post_edge", b.rd1, 8'h3C);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
